// File: rtl/decode_64b_67b_sync_if.sv
// Bus between the RX gearbox, the 64B/67B sync decoder and its payload consumer.
// The slave modport is the decoder's view; master is the gearbox/consumer view.
interface decode_64b_67b_sync_if;
    logic [66:0] data_in;
    logic        data_in_valid;
    logic        passthrough;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_out_valid;
    logic        header_err;
    logic        block_lock;
    logic        slip;
    logic        disp_err;

    modport slave (
        input  data_in, data_in_valid, passthrough,
        output data_out, header_out, data_out_valid, header_err,
               block_lock, slip, disp_err
    );

    modport master (
        output data_in, data_in_valid, passthrough,
        input  data_out, header_out, data_out_valid, header_err,
               block_lock, slip, disp_err
    );
endinterface

// File: rtl/decode_64b_67b_sync.sv
// 64B/67B receive decoder: sync-header block lock with gearbox bit-slip requests,
// inversion removal and bounded running-disparity monitoring.
module decode_64b_67b_sync #(
    parameter int LOCK_CNT   = 64,
    parameter int WIN_LEN    = 64,
    parameter int BAD_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32,
    parameter int DISP_LIMIT = 96
) (
    input  logic                         i_user_clk,
    input  logic                         i_system_reset,
    decode_64b_67b_sync_if.slave         io_bus
);
    localparam int CW = 16;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] BAD_LAST  = CW'(BAD_LIMIT - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SLIP_WAIT - 1);
    localparam logic signed [15:0] DISP_LIM_C = 16'(DISP_LIMIT);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_SLIP_WAIT, ST_LOCKED} state_t;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int k = 0; k < 64; k++) c = c + 7'(v[k]);
        return c;
    endfunction

    function automatic logic signed [15:0] sat_rd(input logic signed [17:0] v);
        if (v > 18'sd32767)       return 16'sd32767;
        else if (v < -18'sd32767) return -16'sd32767;
        else                      return v[15:0];
    endfunction

    function automatic logic disp_over(input logic signed [15:0] v);
        return (v > DISP_LIM_C) || (v < -DISP_LIM_C);
    endfunction

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_good_cnt, w_good_nxt;
    logic [CW-1:0]         r_wait_cnt, w_wait_nxt;
    logic [CW-1:0]         r_win_cnt,  w_win_nxt;
    logic [CW-1:0]         r_bad_cnt,  w_bad_nxt;
    logic signed [15:0]    r_rd,       w_rd_nxt;
    logic                  r_block_lock, w_lock_nxt;
    logic                  r_slip,       w_slip_nxt;
    logic                  r_disp_err,   w_derr_nxt;

    logic [63:0]           r_data_p1;
    logic [1:0]            r_hdr_p1;
    logic                  r_vld_p1;
    logic                  r_herr_p1;

    logic [1:0]            w_hdr;
    logic                  w_hdr_good;
    logic [6:0]            w_pc;
    logic signed [8:0]     w_contrib;
    logic signed [17:0]    w_rd_wide;
    logic signed [15:0]    w_rd_sum;

    // Disparity counts the bits as transmitted, before inversion removal.
    always_comb begin
        w_hdr      = io_bus.data_in[65:64];
        w_hdr_good = ^w_hdr;
        w_pc       = popcount(io_bus.data_in[63:0]);
        w_contrib  = 9'({w_pc, 1'b0}) - 9'd64 + (io_bus.data_in[66] ? 9'd1 : 9'h1FF);
        w_rd_wide  = {{2{r_rd[15]}}, r_rd} + {{9{w_contrib[8]}}, w_contrib};
        w_rd_sum   = sat_rd(w_rd_wide);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_win_nxt   = r_win_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_rd_nxt    = r_rd;
        w_lock_nxt  = r_block_lock;
        w_slip_nxt  = 1'b0;
        w_derr_nxt  = r_disp_err;
        if (io_bus.passthrough) begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = '0;
            w_wait_nxt  = '0;
            w_win_nxt   = '0;
            w_bad_nxt   = '0;
            w_rd_nxt    = '0;
            w_lock_nxt  = 1'b0;
            w_derr_nxt  = 1'b0;
        end else if (io_bus.data_in_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (!w_hdr_good) begin
                        w_good_nxt  = '0;
                        w_wait_nxt  = '0;
                        w_slip_nxt  = 1'b1;
                        w_state_nxt = ST_SLIP_WAIT;
                    end else if (r_good_cnt == LOCK_LAST) begin
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_rd_nxt    = '0;
                        w_lock_nxt  = 1'b1;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
                ST_SLIP_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_wait_nxt  = '0;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_UNLOCKED;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Loss of lock wins over a window boundary on the same word.
                    if (!w_hdr_good && (r_bad_cnt == BAD_LAST)) begin
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_wait_nxt  = '0;
                        w_good_nxt  = '0;
                        w_rd_nxt    = '0;
                        w_lock_nxt  = 1'b0;
                        w_derr_nxt  = 1'b0;
                        w_slip_nxt  = 1'b1;
                        w_state_nxt = ST_SLIP_WAIT;
                    end else begin
                        w_rd_nxt   = w_rd_sum;
                        w_derr_nxt = r_disp_err | disp_over(w_rd_sum);
                        if (r_win_cnt == WIN_LAST) begin
                            w_win_nxt = '0;
                            w_bad_nxt = '0;
                        end else begin
                            w_win_nxt = r_win_cnt + 1'b1;
                            w_bad_nxt = r_bad_cnt + CW'(!w_hdr_good);
                        end
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_user_clk or posedge i_system_reset) begin
        if (i_system_reset) begin
            r_state      <= ST_UNLOCKED;
            r_good_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_rd         <= '0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
            r_disp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_win_cnt    <= w_win_nxt;
            r_bad_cnt    <= w_bad_nxt;
            r_rd         <= w_rd_nxt;
            r_block_lock <= w_lock_nxt;
            r_slip       <= w_slip_nxt;
            r_disp_err   <= w_derr_nxt;
        end
    end

    // Output stage: one-cycle datapath, payload held across idle cycles.
    always_ff @(posedge i_user_clk or posedge i_system_reset) begin
        if (i_system_reset) begin
            r_data_p1 <= '0;
            r_hdr_p1  <= '0;
            r_vld_p1  <= 1'b0;
            r_herr_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= io_bus.data_in_valid;
            if (io_bus.data_in_valid) begin
                r_hdr_p1  <= w_hdr;
                r_herr_p1 <= !w_hdr_good;
                r_data_p1 <= (io_bus.data_in[66] && !io_bus.passthrough) ?
                             ~io_bus.data_in[63:0] : io_bus.data_in[63:0];
            end
        end
    end

    assign io_bus.data_out       = r_data_p1;
    assign io_bus.header_out     = r_hdr_p1;
    assign io_bus.data_out_valid = r_vld_p1;
    assign io_bus.header_err     = r_herr_p1;
    assign io_bus.block_lock     = r_block_lock;
    assign io_bus.slip           = r_slip;
    assign io_bus.disp_err       = r_disp_err;
endmodule

// File: tb/tb_decode_64b_67b_sync.sv
// Bench for decode_64b_67b_sync: directed scenarios plus a randomized stream,
// all checked against a word-level behavioural model of the lock/disparity rules.
module tb_decode_64b_67b_sync;
    localparam int LOCK_CNT   = 64;
    localparam int WIN_LEN    = 64;
    localparam int BAD_LIMIT  = 16;
    localparam int SLIP_WAIT  = 32;
    localparam int DISP_LIMIT = 96;
    localparam logic [63:0] PAT = 64'h0123456789ABCDEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_64b_67b_sync_if bus ();

    decode_64b_67b_sync #(
        .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .BAD_LIMIT(BAD_LIMIT),
        .SLIP_WAIT(SLIP_WAIT), .DISP_LIMIT(DISP_LIMIT)
    ) dut (
        .i_user_clk     (clk),
        .i_system_reset (rst),
        .io_bus         (bus)
    );

    // Model: expected outputs plus word-level bookkeeping.
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic        m_vld, m_herr, m_lock, m_slip, m_derr;
    int          good_run, ignore_left, win_pos, bad_in_win, rd;

    function automatic logic [66:0] mk(input logic inv, input logic [1:0] hdr, input logic [63:0] pl);
        return {inv, hdr, pl};
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic logic [70:0] dut_vec();
        return {bus.data_out, bus.header_out, bus.data_out_valid, bus.header_err,
                bus.block_lock, bus.slip, bus.disp_err};
    endfunction

    function automatic logic [70:0] exp_vec();
        return {m_data, m_hdr, m_vld, m_herr, m_lock, m_slip, m_derr};
    endfunction

    task automatic model_reset();
        m_data = '0; m_hdr = '0; m_vld = 0; m_herr = 0; m_lock = 0; m_slip = 0; m_derr = 0;
        good_run = 0; ignore_left = 0; win_pos = 0; bad_in_win = 0; rd = 0;
    endtask

    task automatic model_word(input logic [66:0] d, input logic v, input logic p);
        logic hgood;
        m_slip = 1'b0;
        m_vld  = v;
        if (p) begin
            m_lock = 0; m_derr = 0; good_run = 0; ignore_left = 0;
            win_pos = 0; bad_in_win = 0; rd = 0;
        end
        if (v) begin
            m_hdr  = d[65:64];
            m_herr = (d[65:64] == 2'b00) || (d[65:64] == 2'b11);
            m_data = (d[66] && !p) ? ~d[63:0] : d[63:0];
            hgood  = !m_herr;
            if (!p) begin
                if (ignore_left > 0) begin
                    ignore_left--;
                end else if (!m_lock) begin
                    if (hgood) begin
                        good_run++;
                        if (good_run == LOCK_CNT) begin
                            m_lock = 1; good_run = 0; win_pos = 0; bad_in_win = 0; rd = 0;
                        end
                    end else begin
                        good_run = 0; m_slip = 1; ignore_left = SLIP_WAIT;
                    end
                end else begin
                    if (!hgood) bad_in_win++;
                    if (bad_in_win == BAD_LIMIT) begin
                        m_lock = 0; m_slip = 1; m_derr = 0; ignore_left = SLIP_WAIT;
                        rd = 0; win_pos = 0; bad_in_win = 0; good_run = 0;
                    end else begin
                        rd = clamp(rd + 2 * $countones(d[63:0]) - 64 + (d[66] ? 1 : -1));
                        if (rd > DISP_LIMIT || rd < -DISP_LIMIT) m_derr = 1;
                        win_pos++;
                        if (win_pos == WIN_LEN) begin
                            win_pos = 0; bad_in_win = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [66:0] d, input logic v, input logic p);
        bus.data_in = d; bus.data_in_valid = v; bus.passthrough = p;
        @(posedge clk); #1;
        model_word(d, v, p);
    endtask

    task automatic do_reset();
        bus.data_in = '0; bus.data_in_valid = 0; bus.passthrough = 0;
        rst = 1; #2; rst = 0;
        model_reset();
    endtask

    task automatic acquire_lock();
        for (int i = 0; i < LOCK_CNT; i++) step(mk(0, 2'b01, PAT), 1, 0);
    endtask

    task automatic test_reset();
        bus.data_in = '0; bus.data_in_valid = 0; bus.passthrough = 0;
        #2; rst = 1; #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_async: got %h expected %h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1; rst = 0;
        step(mk(0, 2'b01, 64'h0), 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_lock_acquire();
        do_reset();
        for (int i = 1; i <= LOCK_CNT; i++) begin
            step(mk(0, 2'b01, PAT), 1, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL acquire word %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == LOCK_CNT - 1) begin
                checks++;
                if (bus.block_lock !== 1'b0) begin
                    errors++; $display("FAIL acquire_early_lock: got %b expected 0", bus.block_lock);
                end
            end
        end
        checks++;
        if (bus.block_lock !== 1'b1 || bus.slip !== 1'b0) begin
            errors++; $display("FAIL acquire_lock: lock %b slip %b expected 1 0", bus.block_lock, bus.slip);
        end
        checks++;
        if (bus.data_out !== PAT) begin
            errors++; $display("FAIL acquire_data: got %h expected %h", bus.data_out, PAT);
        end
    endtask

    task automatic test_inversion();
        step(mk(1, 2'b01, 64'hFFFFFFFF00000000), 1, 0);
        checks++;
        if (bus.data_out !== 64'h00000000FFFFFFFF) begin
            errors++; $display("FAIL invert_data: got %h expected 00000000ffffffff", bus.data_out);
        end
        checks++;
        if (bus.disp_err !== 1'b0 || bus.block_lock !== 1'b1 || rd != 1) begin
            errors++; $display("FAIL invert_disp: derr %b lock %b model rd %0d expected 0 1 1",
                               bus.disp_err, bus.block_lock, rd);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL invert_vec: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_slip();
        int nslip;
        do_reset();
        for (int i = 0; i < 9; i++) step(mk(0, 2'b10, PAT), 1, 0);
        step(mk(0, 2'b11, PAT), 1, 0);
        checks++;
        if (bus.header_err !== 1'b1 || bus.slip !== 1'b1) begin
            errors++; $display("FAIL slip_pulse: herr %b slip %b expected 1 1", bus.header_err, bus.slip);
        end
        nslip = 0;
        for (int i = 0; i < SLIP_WAIT; i++) begin
            step(mk(0, 2'b00, PAT), 1, 0);
            if (bus.slip === 1'b1) nslip++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL slip_wait word %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (nslip != 0) begin
            errors++; $display("FAIL slip_wait_quiet: got %0d pulses expected 0", nslip);
        end
        step(mk(0, 2'b00, PAT), 1, 0);
        checks++;
        if (bus.slip !== 1'b1) begin
            errors++; $display("FAIL slip_resume: got %b expected 1", bus.slip);
        end
        for (int i = 0; i < SLIP_WAIT; i++) step(mk(0, 2'b01, PAT), 1, 0);
        for (int i = 1; i <= LOCK_CNT; i++) begin
            step(mk(0, 2'b01, PAT), 1, 0);
            checks++;
            if (bus.block_lock !== (i == LOCK_CNT)) begin
                errors++; $display("FAIL slip_relock word %0d: got %b expected %b", i, bus.block_lock, i == LOCK_CNT);
            end
        end
    endtask

    task automatic test_bad_window();
        do_reset();
        acquire_lock();
        for (int w = 0; w < 2; w++) begin
            for (int pos = 0; pos < WIN_LEN; pos++) begin
                step(mk(0, ((w == 0 && pos < 15) || (w == 1 && pos >= 49)) ? 2'b11 : 2'b10, PAT), 1, 0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++; $display("FAIL window%0d pos %0d: got %h expected %h", w, pos, dut_vec(), exp_vec());
                end
            end
            checks++;
            if (bus.block_lock !== 1'b1) begin
                errors++; $display("FAIL window%0d_hold: got %b expected 1", w, bus.block_lock);
            end
        end
        for (int pos = 0; pos < BAD_LIMIT; pos++) begin
            step(mk(0, 2'b00, PAT), 1, 0);
            if (pos < BAD_LIMIT - 1) begin
                checks++;
                if (bus.block_lock !== 1'b1 || bus.slip !== 1'b0) begin
                    errors++; $display("FAIL window_early_loss pos %0d: lock %b slip %b", pos, bus.block_lock, bus.slip);
                end
            end
        end
        checks++;
        if (bus.block_lock !== 1'b0 || bus.slip !== 1'b1) begin
            errors++; $display("FAIL window_loss: lock %b slip %b expected 0 1", bus.block_lock, bus.slip);
        end
        step(mk(0, 2'b00, PAT), 1, 0);
        checks++;
        if (bus.slip !== 1'b0) begin
            errors++; $display("FAIL window_slip_width: got %b expected 0", bus.slip);
        end
    endtask

    task automatic test_disparity();
        do_reset();
        acquire_lock();
        step(mk(0, 2'b01, '1), 1, 0);
        checks++;
        if (bus.disp_err !== 1'b0) begin
            errors++; $display("FAIL disp_first: got %b expected 0", bus.disp_err);
        end
        step(mk(0, 2'b01, '1), 1, 0);
        checks++;
        if (bus.disp_err !== 1'b1) begin
            errors++; $display("FAIL disp_second: got %b expected 1", bus.disp_err);
        end
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 2'b10, '1), 1, 0);
            checks++;
            if (bus.disp_err !== 1'b1 || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL disp_sticky %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_valid_toggle_reset();
        int  nvalid, cyc;
        logic v;
        do_reset();
        nvalid = 0; cyc = 0;
        while (nvalid < LOCK_CNT && cyc < 1000) begin
            v = 1'($urandom % 2);
            step(mk(1'($urandom % 2), 2'b10, {$urandom, $urandom}), v, 0);
            if (v) nvalid++;
            cyc++;
            checks++;
            if (bus.block_lock !== (nvalid >= LOCK_CNT) || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL toggle cyc %0d valid %0d: got %h expected %h", cyc, nvalid, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (nvalid < LOCK_CNT) begin
            errors++; $display("FAIL toggle_budget: got %0d valid words expected %0d", nvalid, LOCK_CNT);
        end
        step(mk(0, 2'b00, PAT), 1, 0);
        rst = 1; #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL midstream_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        #1; rst = 0;
        for (int i = 0; i < LOCK_CNT - 1; i++) step(mk(0, 2'b01, PAT), 1, 0);
        checks++;
        if (bus.block_lock !== 1'b0) begin
            errors++; $display("FAIL reset_relock_early: got %b expected 0", bus.block_lock);
        end
    endtask

    task automatic test_passthrough();
        do_reset();
        acquire_lock();
        step(mk(1, 2'b01, PAT), 1, 1);
        checks++;
        if (bus.data_out !== PAT) begin
            errors++; $display("FAIL pass_data: got %h expected %h", bus.data_out, PAT);
        end
        checks++;
        if (bus.block_lock !== 1'b0 || bus.slip !== 1'b0 || bus.disp_err !== 1'b0) begin
            errors++; $display("FAIL pass_ctrl: lock %b slip %b derr %b expected 0 0 0",
                               bus.block_lock, bus.slip, bus.disp_err);
        end
        for (int i = 0; i < 8; i++) begin
            step(mk(1'($urandom % 2), 2'($urandom), {$urandom, $urandom}), 1, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL pass_stream %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  hdr;
        logic [63:0] pl;
        logic        v, p;
        int          bad_mod;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bad_mod = (i < 1000) ? 400 : ((i < 2000) ? 40 : 5);
            v   = ($urandom % 4) != 0;
            p   = ($urandom % 300) == 0;
            hdr = (($urandom % bad_mod) == 0) ? (($urandom % 2) ? 2'b00 : 2'b11)
                                              : (($urandom % 2) ? 2'b01 : 2'b10);
            pl  = (($urandom % 8) == 0) ? '1 : {$urandom, $urandom};
            step(mk(1'($urandom % 2), hdr, pl), v, p);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.data_in = '0; bus.data_in_valid = 0; bus.passthrough = 0;
        model_reset();
        test_reset();
        test_lock_acquire();
        test_inversion();
        test_slip();
        test_bad_window();
        test_disparity();
        test_valid_toggle_reset();
        test_passthrough();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
